// File: rtl/serial_twos_deserializer_pkg.sv
// Shared types for the serial two's-complement receive path.
package serial_twos_deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-index counter width; a WIDTH of 2 still needs one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_twos_deserializer_if.sv
// Serial-in / parallel-out handshake bundle; slave is the deserializer's view.
interface serial_twos_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_start;
  logic             in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             frame_err;

  modport master (
    output in_valid, in_start, in_data, out_ready,
    input  in_ready, out_valid, result, overflow, frame_err
  );

  modport slave (
    input  in_valid, in_start, in_data, out_ready,
    output in_ready, out_valid, result, overflow, frame_err
  );
endinterface

// File: rtl/serial_twos_deserializer_negator.sv
// 1-bit serial two's-complement cell: copy up to the first 1, invert afterwards.
// Combinational output; clear affects the bit presented in the same cycle.
module twos_bit_negator (
  input  logic clk,
  input  logic rst,
  input  logic b,
  input  logic en,
  input  logic clear,
  output logic nb,
  output logic seen_one
);

  logic seen_q;
  logic seen_eff;

  assign seen_eff = seen_q & ~clear;
  assign nb       = seen_eff ? ~b : b;
  assign seen_one = seen_eff;

  always_ff @(posedge clk) begin
    if (rst)
      seen_q <= 1'b0;
    else if (en)
      seen_q <= seen_eff | b;
    else if (clear)
      seen_q <= 1'b0;
  end

endmodule

// File: rtl/serial_twos_deserializer.sv
// LSB-first serial negator and deserializer; result valid 1 cycle after the last bit.
// in_ready drops while a finished word waits for out_ready; bits offered then are dropped.
module serial_twos_deserializer
  import serial_twos_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                          clk,
  input logic                          rst,
  serial_twos_deserializer_if.slave    bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             frame_err_q;
  logic             accept;
  logic             proc;
  logic             last;
  logic             consume;
  logic             clear;
  logic             nb;
  logic             seen_one;

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  // In IDLE only a start-qualified bit opens a frame; in SHIFT every accepted bit counts.
  assign proc    = accept && (bus.in_start || state == SHIFT);
  assign idx     = bus.in_start ? '0 : cnt;
  assign last    = (idx == CW'(WIDTH - 1));
  assign consume = (state == DONE) && bus.out_ready;
  assign clear   = (accept && bus.in_start) || consume;

  twos_bit_negator u_neg (
    .clk      (clk),
    .rst      (rst),
    .b        (bus.in_data),
    .en       (proc),
    .clear    (clear),
    .nb       (nb),
    .seen_one (seen_one)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (proc) state_nxt = last ? DONE : SHIFT;
      SHIFT:   if (proc && last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= accept && bus.in_start && (state == SHIFT);
      if (proc) begin
        result_q[idx] <= nb;
        cnt           <= last ? '0 : idx + 1'b1;
        if (last)
          overflow_q <= bus.in_data && !seen_one;
      end else if (consume) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_twos_deserializer.sv
// Directed bench for serial_twos_deserializer at WIDTH=8.
module tb_serial_twos_deserializer;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  serial_twos_deserializer_if #(.WIDTH(W)) bus ();

  serial_twos_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic start);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_start = start;
    tick();
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_data  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] v);
    for (int i = 0; i < W; i++)
      send_bit(v[i], i == 0);
  endtask

  task automatic chk_done(input string tag, input logic [W-1:0] exp_res, input logic exp_ov);
    chk({tag, "_vld"}, W'(bus.out_valid), W'(1));
    chk({tag, "_res"}, bus.result, exp_res);
    chk({tag, "_ov"},  W'(bus.overflow), W'(exp_ov));
    chk({tag, "_rdy"}, W'(bus.in_ready), W'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, W'(bus.out_valid), W'(0));
    chk({tag, "_rdy"}, W'(bus.in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] fa;
    logic [W-1:0] f03;
    tests  = 0;
    failed = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_start  = 1'b0;
    bus.in_data   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_vld", W'(bus.out_valid), W'(0));
    chk("rst_rdy", W'(bus.in_ready), W'(1));
    chk("rst_res", bus.result, 8'h00);
    chk("rst_ov",  W'(bus.overflow), W'(0));
    chk("rst_ferr", W'(bus.frame_err), W'(0));
    rst = 1'b0;
    tick();

    // bits ignored in IDLE without a start strobe
    send_bit(1'b1, 1'b0);
    chk_idle("idle_nostart");

    send_frame(8'h05);
    chk_done("f05", 8'hFB, 1'b0);
    tick();
    chk_idle("f05_cons");

    // 0xFA with a two-cycle gap after bit 3
    fa = 8'hFA;
    for (int i = 0; i < 4; i++) send_bit(fa[i], i == 0);
    tick();
    tick();
    chk("gap_vld", W'(bus.out_valid), W'(0));
    for (int i = 4; i < W; i++) send_bit(fa[i], 1'b0);
    chk_done("fFA", 8'h06, 1'b0);
    tick();

    send_frame(8'h80);
    chk_done("f80", 8'h80, 1'b1);
    tick();
    send_frame(8'h00);
    chk_done("f00", 8'h00, 1'b0);
    tick();
    send_frame(8'h01);
    chk_done("f01", 8'hFF, 1'b0);
    tick();

    // backpressure: stall 4 cycles while offering start bits
    bus.out_ready = 1'b0;
    send_frame(8'h05);
    chk_done("bp0", 8'hFB, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_start = 1'b1;
    bus.in_data  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_done("bp_hold", 8'hFB, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_data  = 1'b0;
    chk_idle("bp_rel");
    chk("bp_res", bus.result, 8'hFB);
    tick();
    chk_idle("bp_idle2");

    // restart: 3 bits then a new start with 0x03
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("pre_ferr", W'(bus.frame_err), W'(0));
    f03 = 8'h03;
    send_bit(f03[0], 1'b1);
    chk("rs_ferr1", W'(bus.frame_err), W'(1));
    send_bit(f03[1], 1'b0);
    chk("rs_ferr0", W'(bus.frame_err), W'(0));
    for (int i = 2; i < W; i++) send_bit(f03[i], 1'b0);
    chk_done("f03", 8'hFD, 1'b0);
    chk("f03_ferr", W'(bus.frame_err), W'(0));
    tick();

    // reset mid-frame
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    tick();
    chk("mr_vld", W'(bus.out_valid), W'(0));
    chk("mr_rdy", W'(bus.in_ready), W'(1));
    chk("mr_res", bus.result, 8'h00);
    chk("mr_ov",  W'(bus.overflow), W'(0));
    rst = 1'b0;
    send_frame(8'h02);
    chk_done("f02", 8'hFE, 1'b0);
    tick();
    chk_idle("end");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_twos_deserializer.md
Name: serial_twos_deserializer

Overview:
Receive end of the serial two's-complement datapath. Accepts an LSB-first serial bit stream framed by a start strobe and negates it on the fly (copy bits up to and including the first 1, invert every later bit). Assembles the negated bits into a WIDTH-bit parallel word and presents it on a valid/ready output handshake. Sits between the serial link and the parallel datapath, with backpressure toward the serial source.

Parameters:
WIDTH, 8, frame length in bits and width of the parallel result; legal range is 2 or more.

Ports:
clk  input  1  single clock; all logic on posedge clk.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  a serial bit is present on in_data this cycle.
in_start  input  1  qualifies the current bit as bit 0 (LSB) of a new frame.
in_data  input  1  serial data bit, LSB first.
in_ready  output  1  block can accept a bit this cycle.
out_valid  output  1  result holds a complete negated word.
out_ready  input  1  downstream accepts the result.
result  output  WIDTH  negated word; bit i is the negation of received bit i.
overflow  output  1  valid with out_valid; input word was the most negative value (1 followed by WIDTH-1 zeros).
frame_err  output  1  one-cycle pulse when an in-progress frame is aborted by a new in_start.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, result=0, out_valid=0, overflow=0, frame_err=0, in_ready=1, bit counter=0, seen_one=0. Reset wins over every other event, including a reset mid-frame or while out_valid is high.
- Accept = in_valid && in_ready. Bits arriving while in_ready=0 are dropped and have no effect.
- State IDLE: in_ready=1. Accepted bits with in_start=0 are ignored. An accepted bit with in_start=1 is processed as bit 0; the block then moves to SHIFT, or to DONE when WIDTH is reached.
- Bit processing for accepted bit b at index i: result[i] = seen_one ? ~b : b; then seen_one = seen_one | b; counter = i+1.
- State SHIFT: in_ready=1. An accepted bit with in_start=0 is the next bit. An accepted bit with in_start=1 restarts the frame: counter and seen_one are cleared, the bit is processed as bit 0, and frame_err pulses for 1 cycle. Cycles with no accepted bit hold all state.
- After bit WIDTH-1 is accepted, the next cycle is DONE with out_valid=1 and in_ready=0. Latency from the last bit to out_valid is 1 cycle.
- Overflow: when the last bit is accepted, overflow = (b==1) && !seen_one. It is held with result.
- All-zero input gives result 0 and overflow 0.
- State DONE: result and overflow stay stable while out_valid=1 and out_ready=0. When out_valid && out_ready, the next cycle is IDLE with out_valid=0, in_ready=1 and seen_one/counter cleared. result keeps its last value; only out_valid marks it valid.
- No bypass: a new frame cannot start in the same cycle the result is consumed. Minimum frame period is WIDTH+1 cycles.
- frame_err is 0 in every cycle except the abort-pulse cycle.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, DONE) and the counter-width constant computed as clog2(WIDTH).
- One natural sub-module: twos_bit_negator, a 1-bit sequential cell holding seen_one. Inputs: b, en, clear. Output: the negated bit. It pairs with a serial negator on the transmit side.
- The top level holds the FSM, the counter, the result register and the handshake.

Test Plan:
- WIDTH=8, frame 0x05 (bits 1,0,1,0,0,0,0,0 LSB-first), in_valid every cycle, out_ready=1 -> out_valid 1 cycle after the last bit; result=0xFB; overflow=0.
- Frame bits 0,1,0,1,1,1,1,1 (0xFA) with gaps: in_valid low for 2 cycles mid-frame -> result=0x06; gaps do not change the bit index.
- Frame 0x80 -> result=0x80, overflow=1. Frame 0x00 -> result=0x00, overflow=0. Frame 0x01 -> result=0xFF.
- Backpressure: after frame 0x05, hold out_ready=0 for 4 cycles while driving in_valid=1 with in_start=1 -> in_ready=0; result stays 0xFB; incoming bits are dropped; accepted on the 5th cycle, IDLE next cycle.
- Restart: 3 bits of a frame, then in_start=1 with frame 0x03 -> frame_err pulses once; result=0xFD.
- Reset: assert rst after 4 bits of a frame -> all outputs at reset values next cycle; a following full frame 0x02 -> result=0xFE.
